// File: rtl/sqrt_arb_pkg.sv
// Shared widths and tag type for the sqrt arbiter slice.
package sqrt_arb_pkg;

    localparam int RAD_W  = 16;
    localparam int ROOT_W = 8;
    localparam int REM_W  = 9;
    localparam int IDX_W  = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/sqrt_rr_arb.sv
// Round-robin arbiter: search begins one past the pointer, wrapping modulo NREQ.
module sqrt_rr_arb #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] gidx
);

    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant = '0;
        gidx  = ptr;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((int'(ptr) + int'(k)) % NREQ);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                gidx        = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one external sqrt_16bit datapath among NREQ requesters; results return in order.
// Optional SQRT_ARB_PERF_EN adds saturating per-requester grant counters (grant_cnt).
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SQRT_LAT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*RAD_W-1:0]  req_radical,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [ROOT_W-1:0]      rsp_q,
    output logic [REM_W-1:0]       rsp_remainder,
    output logic [RAD_W-1:0]       sqrt_radical,
    input  logic [ROOT_W-1:0]      sqrt_q,
    input  logic [REM_W-1:0]       sqrt_remainder,
`ifdef SQRT_ARB_PERF_EN
    output logic [NREQ*16-1:0]     grant_cnt,
`endif
    output logic                   busy
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic [NREQ-1:0]  grant;
    logic             fire;
    logic             rsp_vld;
    logic [IDX_W-1:0] rsp_idx;
    tag_t             tags [SQRT_LAT+1];

    sqrt_rr_arb #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    always_comb begin
        req_ready = (en && !flush && rst_n) ? grant : '0;
        fire      = |(req_valid & req_ready);
    end

    // Tag stage k lines up with the radical issued k+1 cycles earlier, so stage SQRT_LAT meets sqrt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= PTR_W'(NREQ - 1);
            sqrt_radical  <= '0;
            rsp_vld       <= 1'b0;
            rsp_idx       <= '0;
            rsp_q         <= '0;
            rsp_remainder <= '0;
            for (int unsigned k = 0; k <= SQRT_LAT; k++) tags[k] <= '0;
        end else begin
            if (fire) begin
                ptr          <= gidx;
                sqrt_radical <= req_radical[int'(gidx)*RAD_W +: RAD_W];
            end
            tags[0] <= '{valid: fire, idx: IDX_W'(gidx)};
            for (int unsigned k = 1; k <= SQRT_LAT; k++) tags[k] <= tags[k-1];
            rsp_vld <= tags[SQRT_LAT].valid && !flush;
            if (tags[SQRT_LAT].valid && !flush) begin
                rsp_idx       <= tags[SQRT_LAT].idx;
                rsp_q         <= sqrt_q;
                rsp_remainder <= sqrt_remainder;
            end
            if (flush) begin
                for (int unsigned k = 0; k <= SQRT_LAT; k++) tags[k].valid <= 1'b0;
            end
        end
    end

    always_comb begin
        busy = rsp_vld;
        for (int unsigned k = 0; k <= SQRT_LAT; k++) busy = busy | tags[k].valid;
        for (int unsigned i = 0; i < NREQ; i++) rsp_valid[i] = rsp_vld && (rsp_idx == IDX_W'(i));
    end

`ifdef SQRT_ARB_PERF_EN
    logic [15:0] cnt [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (fire && gidx == PTR_W'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter with a SQRT_LAT-cycle behavioural sqrt datapath.
module tb_sqrt_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              flush;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*16-1:0] req_radical;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_q;
    logic [8:0]        rsp_remainder;
    logic [15:0]       sqrt_radical;
    logic [7:0]        sqrt_q;
    logic [8:0]        sqrt_remainder;
    logic              busy;
`ifdef SQRT_ARB_PERF_EN
    logic [NREQ*16-1:0] grant_cnt;
`endif

    sqrt_arbiter #(.NREQ(NREQ), .SQRT_LAT(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_radical    (req_radical),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_q          (rsp_q),
        .rsp_remainder  (rsp_remainder),
        .sqrt_radical   (sqrt_radical),
        .sqrt_q         (sqrt_q),
        .sqrt_remainder (sqrt_remainder),
`ifdef SQRT_ARB_PERF_EN
        .grant_cnt      (grant_cnt),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // External datapath: sqrt_q reflects the radical presented LAT cycles earlier.
    logic [15:0] dly [LAT];
    always @(posedge clk) begin
        dly[0] <= sqrt_radical;
        for (int k = 1; k < LAT; k++) dly[k] <= dly[k-1];
    end

    function automatic logic [7:0] isqrt(input logic [15:0] r);
        int q = 0;
        int t;
        for (int b = 7; b >= 0; b--) begin
            t = q | (1 << b);
            if (t * t <= int'(r)) q = t;
        end
        return 8'(q);
    endfunction

    assign sqrt_q         = isqrt(dly[LAT-1]);
    assign sqrt_remainder = 9'(dly[LAT-1] - 16'(sqrt_q) * 16'(sqrt_q));

    typedef struct {
        int idx;
        int q;
        int rem;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp_valid", int'(rsp_valid), 0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_valid", int'(rsp_valid), 1 << e.idx);
                chk("rsp_q", int'(rsp_q), e.q);
                chk("rsp_remainder", int'(rsp_remainder), e.rem);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string nm, input int gi, input int q, input int rem, input bit push);
        #1;
        chk(nm, int'(req_ready), 1 << gi);
        if (push) sbq.push_back('{gi, q, rem, cyc + LAT + 2});
        step();
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy || sbq.size() != 0) && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", int'(busy || sbq.size() != 0), 0);
    endtask

    int qs[4]   = '{0, 1, 1, 1};
    int rems[4] = '{0, 0, 1, 2};
    int rr5[5]  = '{2, 3, 0, 1, 2};

    initial begin
        rst_n       = 1'b0;
        en          = 1'b1;
        flush       = 1'b0;
        req_valid   = '1;
        req_radical = '0;
        #2;
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sqrt_radical", int'(sqrt_radical), 0);
        chk("reset_rsp_q", int'(rsp_q), 0);
        chk("reset_rsp_rem", int'(rsp_remainder), 0);
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Round-robin under full load from reset: 0,1,2,3,0,...
        req_radical = {NREQ{16'hFFFF}};
        req_valid   = '1;
        for (int i = 0; i < 8; i++) expect_grant("rr_grant", i % 4, 255, 510, 1'b1);
        req_valid = '0;
        wait_idle(40);

        // Single request latency and hold behaviour.
        req_radical[15:0] = 16'd1000;
        req_valid         = 4'b0001;
        expect_grant("single_grant", 0, 31, 39, 1'b1);
        req_valid = '0;
        chk("sqrt_radical_capture", int'(sqrt_radical), 1000);
        repeat (10) step();
        chk("busy_after_single", int'(busy), 0);
        chk("rsp_q_hold", int'(rsp_q), 31);
        chk("rsp_rem_hold", int'(rsp_remainder), 39);

        // Back-to-back issue from one requester.
        req_valid = 4'b0100;
        for (int v = 0; v < 4; v++) begin
            req_radical[32 +: 16] = 16'(v);
            expect_grant("req2_grant", 2, qs[v], rems[v], 1'b1);
        end
        req_valid = '0;
        wait_idle(40);

        // Grant enable low blocks grants.
        en        = 1'b0;
        req_valid = '1;
        #1;
        chk("en_low_ready", int'(req_ready), 0);
        step();
        en        = 1'b1;
        req_valid = '0;

        // Flush discards in-flight work; pointer unchanged.
        req_radical[48 +: 16] = 16'd50;
        req_radical[0 +: 16]  = 16'd60;
        req_valid = 4'b1001;
        expect_grant("flush_g3", 3, 0, 0, 1'b0);
        expect_grant("flush_g0", 0, 0, 0, 1'b0);
        req_valid = '0;
        step();
        flush     = 1'b1;
        req_valid = '1;
        #1;
        chk("flush_ready", int'(req_ready), 0);
        step();
        flush     = 1'b0;
        req_valid = '0;
        chk("busy_after_flush", int'(busy), 0);
        req_radical[16 +: 16] = 16'd100;
        req_valid = '1;
        expect_grant("after_flush_grant", 1, 10, 0, 1'b1);
        req_valid = '0;
        wait_idle(40);
        repeat (3) step();

        // Reset with five operations in flight.
        req_radical = {NREQ{16'd144}};
        req_valid   = '1;
        for (int i = 0; i < 5; i++) expect_grant("pre_reset_grant", rr5[i], 0, 0, 1'b0);
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", int'(req_ready), 0);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sqrt_radical", int'(sqrt_radical), 0);
        chk("midrst_rsp_q", int'(rsp_q), 0);
        chk("midrst_rsp_rem", int'(rsp_remainder), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (15) step();
        req_valid = '1;
        expect_grant("post_reset_first", 0, 12, 0, 1'b1);
        req_valid = '0;
        wait_idle(40);

`ifdef SQRT_ARB_PERF_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req_radical[16 +: 16] = 16'd10;
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) expect_grant("perf_grant", 1, 3, 1, 1'b1);
        req_valid = '0;
        wait_idle(40);
        chk("grant_cnt0", int'(grant_cnt[15:0]), 0);
        chk("grant_cnt1", int'(grant_cnt[31:16]), 5);
        chk("grant_cnt2", int'(grant_cnt[47:32]), 0);
        chk("grant_cnt3", int'(grant_cnt[63:48]), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("grant_cnt1_after_flush", int'(grant_cnt[31:16]), 5);
`endif

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
